// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor:
// default parameters, 2-bit counter states and branch-type codes.
package branch_predictor_pkg;

   localparam int BP_XLEN_DEF    = 32;
   localparam int BP_ENTRIES_DEF = 16;
   localparam int BP_CNTW_DEF    = 32;

   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_COND = 2'b01,
      BR_JAL  = 2'b10,
      BR_JALR = 2'b11
   } br_type_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Saturating 2-bit direction counter next-state logic.
// Holds its value when inc and dec are both or neither asserted.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  cnt_e state,
   input  logic inc,
   input  logic dec,
   output cnt_e next_state
);

   always_comb begin
      next_state = state;
      unique case (1'b1)
         inc & ~dec: begin
            if (state != CNT_ST)
               next_state = cnt_e'(state + 2'd1);
         end
         dec & ~inc: begin
            if (state != CNT_SNT)
               next_state = cnt_e'(state - 2'd1);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, zero-latency lookup,
// single-port update from the resolve stage and saturating statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int XLEN    = BP_XLEN_DEF,
   parameter int ENTRIES = BP_ENTRIES_DEF,
   parameter int CNTW    = BP_CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_uncond,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   output logic            mispredict,
   input  logic            flush_tbl,
   output logic [CNTW-1:0] stat_branches,
   output logic [CNTW-1:0] stat_mispredicts
);

   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = XLEN - IDXW - 2;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAGW-1:0]    tag_q [ENTRIES];
   logic [TAGW-1:0]    tag_d [ENTRIES];
   logic [XLEN-1:0]    tgt_q [ENTRIES];
   logic [XLEN-1:0]    tgt_d [ENTRIES];
   cnt_e               cnt_q [ENTRIES];
   cnt_e               cnt_d [ENTRIES];
   logic [CNTW-1:0]    br_q, br_d;
   logic [CNTW-1:0]    mp_q, mp_d;

   logic [IDXW-1:0] if_idx, u_idx;
   logic [TAGW-1:0] if_tag, u_tag;
   logic            u_hit;
   cnt_e            ctr_next;

   assign if_idx = if_pc[IDXW+1:2];
   assign if_tag = if_pc[XLEN-1:IDXW+2];
   assign u_idx  = upd_pc[IDXW+1:2];
   assign u_tag  = upd_pc[XLEN-1:IDXW+2];

   // Lookup reads only the registered table, so a same-cycle update
   // to the same slot is not visible until the following cycle.
   always_comb begin
      pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken  = pred_hit && cnt_q[if_idx][1];
      pred_target = pred_hit ? tgt_q[if_idx] : '0;
   end

   assign mispredict = upd_valid &
      ((upd_taken != upd_pred_taken) |
       (upd_taken & (upd_pred_target != upd_target)));

   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   sat_counter2 u_ctr (
      .state      (cnt_q[u_idx]),
      .inc        (upd_taken),
      .dec        (~upd_taken),
      .next_state (ctr_next)
   );

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      if (flush_tbl) begin
         valid_d = '0;
      end else if (upd_valid) begin
         if (u_hit) begin
            if (upd_uncond) begin
               cnt_d[u_idx] = CNT_ST;
               tgt_d[u_idx] = upd_target;
            end else begin
               cnt_d[u_idx] = ctr_next;
               if (upd_taken)
                  tgt_d[u_idx] = upd_target;
            end
         end else if (upd_taken) begin
            valid_d[u_idx] = 1'b1;
            tag_d[u_idx]   = u_tag;
            tgt_d[u_idx]   = upd_target;
            cnt_d[u_idx]   = upd_uncond ? CNT_ST : CNT_WT;
         end
      end
   end

   // Statistics keep counting through a flush and stick at all-ones.
   always_comb begin
      br_d = br_q;
      mp_d = mp_q;
      if (upd_valid && (br_q != '1))
         br_d = br_q + 1'b1;
      if (mispredict && (mp_q != '1))
         mp_d = mp_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         br_q    <= '0;
         mp_q    <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            cnt_q[i] <= CNT_WNT;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         mp_q    <= mp_d;
      end
   end

   assign stat_branches    = br_q;
   assign stat_mispredicts = mp_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32, PC and target width.
REQ-002 Parameter ENTRIES, default 16, table depth; power of two, 2..256; IDXW = log2(ENTRIES).
REQ-003 Parameter CNTW, default 32, statistics counter width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 if_pc  in  XLEN  fetch-stage PC to predict.
REQ-007 pred_hit  out  1  valid table entry with matching tag for if_pc.
REQ-008 pred_taken  out  1  predict taken.
REQ-009 pred_target  out  XLEN  predicted target; stored target on hit, 0 on miss.
REQ-010 upd_valid  in  1  resolved control-transfer instruction present this cycle.
REQ-011 upd_pc  in  XLEN  PC of the resolved instruction.
REQ-012 upd_uncond  in  1  resolved instruction is an unconditional jump.
REQ-013 upd_taken  in  1  actual outcome.
REQ-014 upd_target  in  XLEN  actual taken target.
REQ-015 upd_pred_taken  in  1  prediction issued for this instruction, carried down the pipeline.
REQ-016 upd_pred_target  in  XLEN  predicted target carried down the pipeline.
REQ-017 mispredict  out  1  combinational redirect request for the update instruction.
REQ-018 flush_tbl  in  1  invalidate the whole table.
REQ-019 stat_branches  out  CNTW  resolved updates counted.
REQ-020 stat_mispredicts  out  CNTW  mispredictions counted.

Function
REQ-021 Index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2]; pc[1:0] ignored.
REQ-022 Each entry holds valid, tag, target (XLEN), 2-bit counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-023 Lookup is combinational, zero latency: pred_hit = valid & tag match; pred_taken = pred_hit & counter[1].
REQ-024 mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_target != upd_target)).
REQ-025 Update hit, conditional: counter saturating +1 when taken, -1 when not taken; no wrap past 11 or below 00.
REQ-026 Update hit, taken: target overwritten with upd_target.
REQ-027 Update hit, upd_uncond: counter forced to ST and target written.
REQ-028 Update miss, taken: allocate (valid=1, tag, target); counter WT, or ST if upd_uncond; prior occupant replaced.
REQ-029 Update miss, not taken: no table change.
REQ-030 Same-cycle lookup and update to the same index: lookup sees pre-update contents; no bypass.
REQ-031 flush_tbl clears every valid bit at the edge; it wins over a simultaneous update, which is dropped from the table but still counted in statistics.
REQ-032 stat_branches +1 per upd_valid cycle; stat_mispredicts +1 when mispredict; both saturate at all-ones and never wrap.

Reset
REQ-033 rst clears all valid bits, sets all counters to WNT, and clears targets, tags and both statistics counters to 0.
REQ-034 After reset, pred_hit=0, pred_taken=0, pred_target=0; mispredict depends only on inputs.
REQ-035 rst asserted mid-operation takes effect immediately, without waiting for clk; any update in that cycle is lost.

Structure
REQ-036 Counter state encodings and default parameter values live in the shared definitions header with the codebase's branch-type constants.
REQ-037 The saturating 2-bit counter next-state logic is one sub-module, sat_counter2 (inputs state, inc, dec; output next state), instantiated once on the update path.
REQ-038 Table storage is flip-flop arrays, not inferred RAM, so reset and flush can act on all entries at once.

Verification
REQ-039 Reset, then if_pc=0x00400010 -> pred_hit=0, pred_taken=0, pred_target=0, stats 0.
REQ-040 Update pc=0x00400010 taken target=0x00400100 pred_taken=0 -> mispredict=1; next cycle lookup hit, taken, target 0x00400100; stat_mispredicts=1.
REQ-041 Same pc, three not-taken updates -> counter WT->WNT->SNT->SNT; pred_taken=0 from the first.
REQ-042 ENTRIES=16, pcs 0x00400010 and 0x00401010 alias; both taken -> second replaces first; lookup of first misses.
REQ-043 Update and lookup same index same cycle -> old prediction shown; new value visible next cycle; flush_tbl with update -> table empty, stat_branches incremented.
REQ-044 CNTW=4, 20 mispredicting updates -> both stats hold 15.
